serial_word_rcvr: RTL
=====================

// Module: serial_word_rcvr
// PURPOSE
//  Serial-to-parallel receive end of the framed serial word link; mates with the parallel-to-serial transmitter.
//  Line idles high; frame = 1 start bit (0), NUM_BITS data bits, 1 stop bit (1), each CLKS_PER_BIT clocks wide.
//  Synchronises the line, finds the start edge, samples mid-bit and shifts bits into a word.
//  Presents the word to the hash/candidate logic with a valid/read handshake plus framing and overrun flags.
// PARAMETERS
//  NUM_BITS      8   data bits per frame (2..32)
//  SHIFT_MSB     1   1: first data bit on the line lands in rx_data[NUM_BITS-1]; 0: it lands in rx_data[0]
//  CLKS_PER_BIT  10  clocks per bit period (>=4; even values give an exact mid-bit sample point)
// PORTS
//  clk            in   1         system clock, all logic on rising edge
//  n_rst          in   1         asynchronous active-low reset
//  serial_in      in   1         asynchronous serial line, idle high
//  data_read      in   1         consumer pulse: rx_data taken, clear data_valid/overrun_error
//  rx_data        out  NUM_BITS  last good word received
//  data_valid     out  1         rx_data holds an unread word
//  framing_error  out  1         last frame had stop bit = 0
//  overrun_error  out  1         a word was written while the previous word was unread
// BEHAVIOUR
//  Reset (async, n_rst=0): rx_data = all 1s; data_valid, framing_error, overrun_error = 0.
//   Synchroniser flops = 1; FSM = IDLE; bit timer and bit counter = 0. Reset mid-frame abandons the frame.
//  Input: 2-flop synchroniser, then 1 edge-detect flop. Start edge = sync'd sample 0 while previous sample 1.
//   Let E be the cycle in which this start edge is detected.
//  FSM states and transitions:
//   IDLE:   on start edge -> START_CHK. Clear framing_error in cycle E.
//   START_CHK: sample at E + CLKS_PER_BIT/2.
//     If the sample is 1 (glitch), go to IDLE with no flags set.
//     Otherwise go to RECV with the timer and the bit counter reset.
//   RECV:   data bit k (k=0..NUM_BITS-1) sampled at E + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
//     Sampled bits shift into a private shift register; rx_data is untouched during RECV.
//     SHIFT_MSB=1: shift left, insert at bit 0. SHIFT_MSB=0: shift right, insert at bit NUM_BITS-1.
//     After bit NUM_BITS-1 -> STOP.
//   STOP:   stop bit sampled at E + CLKS_PER_BIT/2 + (NUM_BITS+1)*CLKS_PER_BIT.
//     If the sample is 1: -> LOAD.
//     If the sample is 0: set framing_error, discard the word, leave rx_data/data_valid unchanged, -> IDLE.
//   LOAD:   one cycle. rx_data <= shift register; data_valid <= 1. Returns to IDLE.
//     rx_data and data_valid are visible 1 cycle after the stop sample.
//  Back-to-back: IDLE accepts a new start edge in the cycle after LOAD or after STOP.
//   The edge detector must see 1 then 0, so a stop bit held low does not retrigger until the line returns high.
//  Handshake:
//   data_read=1 clears data_valid and overrun_error in the next cycle. data_read while data_valid=0 has no effect.
//   In LOAD with data_valid=1 and data_read=0: overwrite rx_data, set overrun_error, data_valid stays 1.
//   In LOAD with data_read=1 in the same cycle: the load wins. data_valid stays 1 and overrun_error = 0.
//  Timer: counts 0..CLKS_PER_BIT-1 and wraps. It is never free-running in IDLE.
//  Counter widths: timer is $clog2(CLKS_PER_BIT) bits; bit counter is $clog2(NUM_BITS+1) bits.
// TESTING (NUM_BITS=8, CLKS_PER_BIT=10, SHIFT_MSB=1 unless noted)
//  1. Reset, idle line -> rx_data=8'hFF, all flags 0. Send frame 0xA5 MSB-first with stop=1:
//     -> rx_data=8'hA5, data_valid=1 one cycle after the stop sample (E+95).
//  2. SHIFT_MSB=0 instance, line bits 1,0,1,0,0,1,0,1 -> rx_data=8'hA5 (first bit in bit 0).
//  3. Line low for 3 clocks then high (glitch) -> no data_valid, no flags set, FSM back in IDLE.
//  4. Frame 0x3C with stop=0 -> framing_error=1; rx_data and data_valid unchanged.
//     Next good frame 0x11 -> framing_error clears at its start edge; rx_data=8'h11.
//  5. Frame 0x01, no read, then frame 0x02 -> rx_data=8'h02, overrun_error=1.
//     data_read pulse -> data_valid=0 and overrun_error=0 next cycle.
//  6. data_read asserted exactly in the LOAD cycle of frame 0x55 -> data_valid=1, overrun_error=0.
//     Separately, n_rst pulsed at mid-frame -> reset values; the following frame 0x77 is received correctly.

Source files
------------

// File: rtl/serial_word_rcvr.sv
// Serial-to-parallel receiver for the framed serial word link: synchronises the line,
// validates the start bit, samples each bit mid-period and hands the word over via valid/read.
module serial_word_rcvr #(
   parameter int NUM_BITS     = 8,
   parameter int SHIFT_MSB    = 1,
   parameter int CLKS_PER_BIT = 10
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                serial_in,
   input  logic                data_read,
   output logic [NUM_BITS-1:0] rx_data,
   output logic                data_valid,
   output logic                framing_error,
   output logic                overrun_error
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(NUM_BITS + 1);
   localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);
   localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      START_CHK,
      RECV,
      STOP,
      LOAD
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic                r_sync1;
   logic                r_sync2;
   logic                r_prev;
   logic [TW-1:0]       r_timer;
   logic [CW-1:0]       r_bitCnt;
   logic [NUM_BITS-1:0] r_shift;
   logic [NUM_BITS-1:0] w_shiftNext;
   logic                w_startEdge;
   logic                w_timerRst;
   logic                w_shiftEn;
   logic                w_load;
   logic                w_setFe;
   logic                w_clrFe;

   assign w_startEdge = r_prev & ~r_sync2;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= serial_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Timer is held at zero whenever the FSM is (or is about to be) idle, so every
   // frame measures its sample points from the detected start edge.
   always_comb begin
      w_nextState = r_state;
      w_timerRst  = 1'b0;
      w_shiftEn   = 1'b0;
      w_load      = 1'b0;
      w_setFe     = 1'b0;
      w_clrFe     = 1'b0;
      case (r_state)
         IDLE: begin
            w_timerRst = 1'b1;
            if (w_startEdge) begin
               w_nextState = START_CHK;
               w_clrFe     = 1'b1;
            end
         end
         START_CHK: begin
            if (r_timer == HALF_M1) begin
               w_timerRst  = 1'b1;
               w_nextState = r_sync2 ? IDLE : RECV;
            end
         end
         RECV: begin
            if (r_timer == FULL_M1) begin
               w_shiftEn = 1'b1;
               if (r_bitCnt == LAST_BIT) begin
                  w_nextState = STOP;
               end
            end
         end
         STOP: begin
            if (r_timer == FULL_M1) begin
               w_timerRst = 1'b1;
               if (r_sync2) begin
                  w_nextState = LOAD;
               end else begin
                  w_nextState = IDLE;
                  w_setFe     = 1'b1;
               end
            end
         end
         LOAD: begin
            w_timerRst  = 1'b1;
            w_load      = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_timerRst  = 1'b1;
            w_nextState = IDLE;
         end
      endcase
   end

   always_comb begin
      w_shiftNext = r_shift;
      if (SHIFT_MSB != 0) begin
         w_shiftNext = {r_shift[NUM_BITS-2:0], r_sync2};
      end else begin
         w_shiftNext = {r_sync2, r_shift[NUM_BITS-1:1]};
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_timer  <= '0;
         r_bitCnt <= '0;
         r_shift  <= '0;
      end else begin
         if (w_timerRst) begin
            r_timer  <= '0;
            r_bitCnt <= '0;
         end else begin
            r_timer <= (r_timer == FULL_M1) ? '0 : r_timer + TMR_ONE;
            if (w_shiftEn) begin
               r_bitCnt <= r_bitCnt + CNT_ONE;
            end
         end
         if (w_shiftEn) begin
            r_shift <= w_shiftNext;
         end
      end
   end

   // A load in the same cycle as a read wins: the new word stays valid and the read
   // only serves to suppress the overrun flag.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_data       <= '1;
         data_valid    <= 1'b0;
         overrun_error <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         if (w_load) begin
            rx_data       <= r_shift;
            data_valid    <= 1'b1;
            overrun_error <= data_valid & ~data_read;
         end else if (data_read && data_valid) begin
            data_valid    <= 1'b0;
            overrun_error <= 1'b0;
         end
         if (w_setFe) begin
            framing_error <= 1'b1;
         end else if (w_clrFe) begin
            framing_error <= 1'b0;
         end
      end
   end

endmodule
